// File: rtl/sha2_pkg.sv
// Shared SHA-2 message-schedule definitions.
// Holds the schedule FSM state encoding, the schedule length per word width
// and the small-sigma rotate/shift amounts for SHA-256 and SHA-512.
package sha2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_EXPAND = 2'd2,
      ST_DRAIN  = 2'd3
   } sched_state_t;

   localparam int ROUNDS_256 = 64;
   localparam int ROUNDS_512 = 80;

   // Small-sigma amounts: {ROTR a, ROTR b, SHR c}.
   localparam int S0_256_A = 7;
   localparam int S0_256_B = 18;
   localparam int S0_256_C = 3;
   localparam int S1_256_A = 17;
   localparam int S1_256_B = 19;
   localparam int S1_256_C = 10;
   localparam int S0_512_A = 1;
   localparam int S0_512_B = 8;
   localparam int S0_512_C = 7;
   localparam int S1_512_A = 19;
   localparam int S1_512_B = 61;
   localparam int S1_512_C = 6;

   function automatic int rounds_for(input int word_w);
      return (word_w == 32) ? ROUNDS_256 : ROUNDS_512;
   endfunction

   // sel: 0 = s0, 1 = s1; k: 0 = first rotate, 1 = second rotate, 2 = shift.
   function automatic int sigma_amt(input int word_w, input int sel, input int k);
      int amt;
      amt = 0;
      if (word_w == 32) begin
         if (sel == 0) amt = (k == 0) ? S0_256_A : (k == 1) ? S0_256_B : S0_256_C;
         else          amt = (k == 0) ? S1_256_A : (k == 1) ? S1_256_B : S1_256_C;
      end else begin
         if (sel == 0) amt = (k == 0) ? S0_512_A : (k == 1) ? S0_512_B : S0_512_C;
         else          amt = (k == 0) ? S1_512_A : (k == 1) ? S1_512_B : S1_512_C;
      end
      return amt;
   endfunction

endpackage

// File: rtl/mod_sigma_small.sv
// Combinational SHA-2 small sigma function.
// Ports:
//   x  in  WORD_W  operand word
//   y  out WORD_W  ROTR(x,a) ^ ROTR(x,b) ^ SHR(x,c)
// SEL=0 selects s0, SEL=1 selects s1; the amounts come from sha2_pkg.
module mod_sigma_small
   import sha2_pkg::*;
#(
   parameter int WORD_W = 32,
   parameter int SEL    = 0
) (
   input  logic [WORD_W-1:0] x,
   output logic [WORD_W-1:0] y
);

   localparam int ROT_A = sigma_amt(WORD_W, SEL, 0);
   localparam int ROT_B = sigma_amt(WORD_W, SEL, 1);
   localparam int SHR_C = sigma_amt(WORD_W, SEL, 2);

   function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] v, input int r);
      return (v >> r) | (v << (WORD_W - r));
   endfunction

   always_comb begin
      y = rotr(x, ROT_A) ^ rotr(x, ROT_B) ^ (x >> SHR_C);
   end

endmodule

// File: rtl/mod_w_sched.sv
// SHA-2 message-schedule generator (SHA-256 for WORD_W=32, SHA-512 for 64).
// Loads 16 message words, then emits W[0..ROUNDS-1] through one output register.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               begin a new block (aborts any block in flight)
//   in_valid/in_ready   message word input handshake, in_data = M[t]
//   out_valid/out_ready schedule word output handshake
//   out_data, out_idx   W[out_idx]
//   busy                high in LOAD, EXPAND and DRAIN
//   done                one-cycle pulse after the last word is consumed
//   dbg_state           current FSM state for observation
// Handshake rule: a transfer happens on any rising edge where valid && ready;
// a holder of valid keeps it and its data stable until that transfer.
module mod_w_sched
   import sha2_pkg::*;
#(
   parameter int WORD_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WORD_W-1:0] out_data,
   output logic [6:0]        out_idx,
   output logic              busy,
   output logic              done,
   output logic [1:0]        dbg_state
);

   localparam int ROUNDS = rounds_for(WORD_W);

   generate
      if (!(WORD_W == 32 || WORD_W == 64)) begin : g_bad_width
         $error("mod_w_sched: WORD_W must be 32 or 64");
      end
   endgenerate

   sched_state_t      state_q, state_d;
   logic [6:0]        t_q;
   logic [WORD_W-1:0] win [16];
   logic              slot_free;
   logic              produce;
   logic              last_load;
   logic              last_word;
   logic [WORD_W-1:0] new_word;
   logic [WORD_W-1:0] s0_val, s1_val;

   mod_sigma_small #(.WORD_W(WORD_W), .SEL(0)) u_s0 (.x(win[1]),  .y(s0_val));
   mod_sigma_small #(.WORD_W(WORD_W), .SEL(1)) u_s1 (.x(win[14]), .y(s1_val));

   assign slot_free = !out_valid || out_ready;
   assign last_load = (t_q == 7'd15);
   assign last_word = (t_q == 7'(ROUNDS - 1));
   assign dbg_state = state_q;

   // Next-state and decoded outputs.
   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      produce  = 1'b0;
      new_word = s1_val + win[9] + s0_val + win[0];
      busy     = (state_q != ST_IDLE);
      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            in_ready = slot_free;
            new_word = in_data;
            produce  = in_valid && slot_free;
            if (produce && last_load) state_d = ST_EXPAND;
         end
         ST_EXPAND: begin
            produce = slot_free;
            if (produce && last_word) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (out_valid && out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      // start wins over every other transition; an input word offered in the
      // same cycle belongs to the aborted block and is discarded.
      if (start) state_d = ST_LOAD;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         t_q       <= 7'd0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_idx   <= 7'd0;
         done      <= 1'b0;
         for (int i = 0; i < 16; i++) win[i] <= '0;
      end else begin
         done <= 1'b0;
         if (start) begin
            // Any consumer handshake this cycle has completed; the stage is
            // simply emptied. The window is refilled by the next 16 loads.
            t_q       <= 7'd0;
            out_valid <= 1'b0;
         end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            if (produce) begin
               out_valid <= 1'b1;
               out_data  <= new_word;
               out_idx   <= t_q;
               t_q       <= t_q + 7'd1;
               for (int i = 0; i < 15; i++) win[i] <= win[i+1];
               win[15] <= new_word;
            end
            if (state_q == ST_DRAIN && out_valid && out_ready) done <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mod_w_sched.sv
// Directed testbench for mod_w_sched, covering both SHA-256 and SHA-512 builds.
module tb_mod_w_sched;
   import sha2_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        in_valid;
   logic [63:0] in_data;
   logic        out_ready;
   logic        sel64;

   logic        in_ready32, out_valid32, busy32, done32;
   logic [31:0] out_data32;
   logic [6:0]  out_idx32;
   logic [1:0]  dbg32;
   logic        in_ready64, out_valid64, busy64, done64;
   logic [63:0] out_data64;
   logic [6:0]  out_idx64;
   logic [1:0]  dbg64;

   logic        in_ready, out_valid, busy, done;
   logic [63:0] out_data;
   logic [6:0]  out_idx;
   logic [1:0]  dbg_state;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [63:0] msg    [16];
   logic [63:0] gold_w [80];
   logic [63:0] got_w  [80];
   logic [63:0] exp_q  [$];
   bit          stopped;

   always #5 clk = ~clk;

   mod_w_sched #(.WORD_W(32)) dut32 (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
      .in_ready(in_ready32), .in_data(in_data[31:0]), .out_valid(out_valid32),
      .out_ready(out_ready), .out_data(out_data32), .out_idx(out_idx32),
      .busy(busy32), .done(done32), .dbg_state(dbg32)
   );

   mod_w_sched #(.WORD_W(64)) dut64 (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
      .in_ready(in_ready64), .in_data(in_data), .out_valid(out_valid64),
      .out_ready(out_ready), .out_data(out_data64), .out_idx(out_idx64),
      .busy(busy64), .done(done64), .dbg_state(dbg64)
   );

   assign in_ready  = sel64 ? in_ready64  : in_ready32;
   assign out_valid = sel64 ? out_valid64 : out_valid32;
   assign out_data  = sel64 ? out_data64  : {32'd0, out_data32};
   assign out_idx   = sel64 ? out_idx64   : out_idx32;
   assign busy      = sel64 ? busy64      : busy32;
   assign done      = sel64 ? done64      : done32;
   assign dbg_state = sel64 ? dbg64       : dbg32;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Golden model: textbook recurrence on the W array.
   function automatic logic [63:0] r32(input logic [31:0] x, input int n);
      logic [31:0] r;
      r = (x >> n) | (x << (32 - n));
      return {32'd0, r};
   endfunction

   function automatic logic [63:0] r64(input logic [63:0] x, input int n);
      return (x >> n) | (x << (64 - n));
   endfunction

   function automatic logic [63:0] sig(input bit w64, input bit s1, input logic [63:0] x);
      if (!w64) begin
         if (!s1) return r32(x[31:0], 7) ^ r32(x[31:0], 18) ^ {32'd0, x[31:0] >> 3};
         else     return r32(x[31:0], 17) ^ r32(x[31:0], 19) ^ {32'd0, x[31:0] >> 10};
      end
      if (!s1) return r64(x, 1) ^ r64(x, 8) ^ (x >> 7);
      return r64(x, 19) ^ r64(x, 61) ^ (x >> 6);
   endfunction

   function automatic void build_gold(input bit w64);
      logic [63:0] mask;
      mask = w64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      exp_q.delete();
      for (int t = 0; t < 80; t++) begin
         if (t < 16) gold_w[t] = msg[t] & mask;
         else gold_w[t] = (sig(w64, 1'b1, gold_w[t-2]) + gold_w[t-7]
                          + sig(w64, 1'b0, gold_w[t-15]) + gold_w[t-16]) & mask;
         exp_q.push_back(gold_w[t]);
      end
   endfunction

   task automatic set_abc(input bit w64);
      for (int i = 0; i < 16; i++) msg[i] = 64'd0;
      msg[0]  = w64 ? 64'h6162_6380_0000_0000 : 64'h0000_0000_6162_6380;
      msg[15] = 64'h18;
   endtask

   task automatic set_random();
      for (int i = 0; i < 16; i++) msg[i] = {$urandom, $urandom};
   endtask

   // Drives one block and scores every output handshake against the model.
   // stop_at >= 0 returns early once that many words have been consumed.
   task automatic run_block(input bit w64, input int bp, input int gap, input bit garbage,
                            input int stop_at, input int exp_done_edge, output bit stop_hit);
      int          k, mi, e, dcnt, dedge, rounds;
      bit          held, acc;
      logic [63:0] hd, exp_w;
      logic [6:0]  hi;
      rounds = w64 ? 80 : 64;
      sel64 = w64;
      build_gold(w64);
      stop_hit = 1'b0;
      k = 0; mi = 0; e = 0; dcnt = 0; dedge = -1; held = 1'b0; hd = '0; hi = '0;
      @(negedge clk);
      start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start_busy", 64'(busy), 64'd1);
      check("start_state", 64'(dbg_state), 64'(ST_LOAD));
      check("start_out_valid", 64'(out_valid), 64'd0);
      while (dcnt == 0 && e < 3000) begin
         if (stop_at >= 0 && k == stop_at) begin
            stop_hit = 1'b1;
            break;
         end
         out_ready = (int'($urandom_range(99)) >= bp);
         if (mi < 16) begin
            in_valid = (int'($urandom_range(99)) >= gap);
            in_data  = msg[mi];
         end else if (garbage) begin
            in_valid = 1'b1;
            in_data  = {$urandom, $urandom};
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (held) begin
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_data", out_data, hd);
            check("stall_idx", 64'(out_idx), 64'(hi));
         end
         if (mi >= 16 && garbage) check("expand_in_ready", 64'(in_ready), 64'd0);
         if (out_valid && out_ready) begin
            exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD;
            check("out_idx", 64'(out_idx), 64'(k));
            check("out_data", out_data, exp_w);
            if (k < 80) got_w[k] = out_data;
            k++;
         end
         held = out_valid && !out_ready;
         hd   = out_data;
         hi   = out_idx;
         acc  = in_valid && in_ready;
         @(posedge clk);
         e++;
         if (acc) mi++;
         @(negedge clk);
         if (done) begin
            dcnt++;
            dedge = e;
         end
      end
      in_valid = 1'b0;
      if (stop_hit) return;
      check("done_seen", 64'(dcnt), 64'd1);
      check("word_count", 64'(k), 64'(rounds));
      if (exp_done_edge > 0) check("done_edge", 64'(dedge), 64'(exp_done_edge));
      check("busy_at_done", 64'(busy), 64'd0);
      @(negedge clk);
      check("done_pulse_width", 64'(done), 64'd0);
      check("idle_state", 64'(dbg_state), 64'(ST_IDLE));
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; sel64 = 1'b0;
      #1;
      check("rst_out_valid32", 64'(out_valid32), 64'd0);
      check("rst_busy32", 64'(busy32), 64'd0);
      check("rst_in_ready32", 64'(in_ready32), 64'd0);
      check("rst_done64", 64'(done64), 64'd0);
      check("rst_out_data64", out_data64, 64'd0);
      check("rst_state64", 64'(dbg64), 64'(ST_IDLE));
      #20;
      @(negedge clk);
      rst_n = 1'b1;

      // SHA-256 "abc", no backpressure.
      set_abc(1'b0);
      run_block(1'b0, 0, 0, 1'b0, -1, 65, stopped);
      check("abc32_w0", got_w[0], 64'h6162_6380);
      check("abc32_w16", got_w[16], 64'h6162_6380);
      check("abc32_w17", got_w[17], 64'h000F_0000);

      // SHA-512 "abc", no backpressure.
      set_abc(1'b1);
      run_block(1'b1, 0, 0, 1'b0, -1, 81, stopped);
      check("abc64_w16", got_w[16], 64'h6162_6380_0000_0000);
      check("abc64_w17", got_w[17], 64'h0003_0000_0000_00C0);

      // Random data with output backpressure and input gaps.
      set_random();
      run_block(1'b0, 50, 30, 1'b0, -1, 0, stopped);
      set_random();
      run_block(1'b1, 50, 30, 1'b0, -1, 0, stopped);

      // Garbage offered during expansion must be ignored.
      set_random();
      run_block(1'b0, 0, 0, 1'b1, -1, 65, stopped);

      // Abort after 30 words, then a fresh block.
      set_random();
      run_block(1'b0, 0, 0, 1'b0, 30, 0, stopped);
      check("abort_reached", 64'(stopped), 64'd1);
      start = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("abort_out_valid", 64'(out_valid), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_state", 64'(dbg_state), 64'(ST_LOAD));
      set_random();
      run_block(1'b0, 0, 0, 1'b0, -1, 65, stopped);

      // Reset mid-block, then a clean "abc" block.
      set_random();
      run_block(1'b0, 0, 0, 1'b0, 20, 0, stopped);
      check("reset_reached", 64'(stopped), 64'd1);
      rst_n = 1'b0;
      #1;
      check("mrst_out_valid", 64'(out_valid), 64'd0);
      check("mrst_out_data", out_data, 64'd0);
      check("mrst_out_idx", 64'(out_idx), 64'd0);
      check("mrst_busy", 64'(busy), 64'd0);
      check("mrst_in_ready", 64'(in_ready), 64'd0);
      check("mrst_done", 64'(done), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      set_abc(1'b0);
      run_block(1'b0, 0, 0, 1'b0, -1, 65, stopped);
      check("post_rst_w17", got_w[17], 64'h000F_0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mod_w_sched.md
# mod_w_sched

Parametrised, clocked SHA-2 message-schedule generator. It accepts the 16 message words of one block over a valid/ready input stream. It then emits the full schedule W[0..ROUNDS-1] over a valid/ready output stream, expanding W[16..] internally from a 16-word sliding window. It sits between the block padder/loader and the compression round engine, and serves both SHA-256 (32-bit, 64 rounds) and SHA-512 (64-bit, 80 rounds).

## Interface
- WORD_W, 32: word width; only 32 (SHA-256) and 64 (SHA-512) are legal; any other value is an elaboration error.
- ROUNDS (localparam), 64 if WORD_W==32 else 80: schedule length.
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous, active-low reset.
- START  in  1  begin a new block; restarts from any state.
- IN_VALID  in  1  IN_DATA holds a message word.
- IN_READY  out  1  block accepts a message word this cycle.
- IN_DATA  in  WORD_W  message word M[t], t=0..15, big-endian word order.
- OUT_VALID  out  1  OUT_DATA/OUT_IDX hold W[OUT_IDX].
- OUT_READY  in  1  consumer accepts the output word.
- OUT_DATA  out  WORD_W  schedule word W[t].
- OUT_IDX  out  7  index t of OUT_DATA.
- BUSY  out  1  high in LOAD, EXPAND and DRAIN.
- DONE  out  1  one-cycle pulse after W[ROUNDS-1] is consumed.

## Operation
- Window w[0..15]: w[15] = W[t-1] (newest), w[0] = W[t-16]. Every produced word shifts the window: w[i] <= w[i+1], and w[15] <= the new word.
- Expansion (t>=16): W[t] = s1(w[14]) + w[9] + s0(w[1]) + w[0], computed modulo 2^WORD_W.
- For WORD_W=32: s0 = ROTR7^ROTR18^SHR3 and s1 = ROTR17^ROTR19^SHR10.
- For WORD_W=64: s0 = ROTR1^ROTR8^SHR7 and s1 = ROTR19^ROTR61^SHR6.
- Output register: OUT_DATA and OUT_IDX form a single registered stage. A word is produced when the stage is empty or is being consumed in the same cycle (slot_free = !OUT_VALID || OUT_READY).
- Counter T (7 bits) holds the index of the next word to produce.
- States:
  - IDLE: IN_READY=0. START moves to LOAD with T=0.
  - LOAD: IN_READY = slot_free. On IN_VALID&&IN_READY, IN_DATA goes to the output register with OUT_IDX=T, the window shifts and T increments. Accepting word 15 moves to EXPAND.
  - EXPAND: IN_READY=0 and IN_VALID is ignored. When slot_free, the expansion result goes to the output register, the window shifts and T increments. Producing W[ROUNDS-1] moves to DRAIN.
  - DRAIN: wait for OUT_VALID&&OUT_READY, then pulse DONE and move to IDLE.
- Reset values: state=IDLE, T=0, window=0, OUT_VALID=0, OUT_DATA=0, OUT_IDX=0, DONE=0. BUSY=0 and IN_READY=0 (both are decoded from state).
- START in any non-IDLE state aborts the current block: next cycle OUT_VALID=0, T=0, state=LOAD. DONE does not pulse. The window does not need clearing, since 16 words are reloaded.
- If START coincides with an output handshake, the handshake completes and START still takes effect.
- RST_N asserted mid-block: all state returns to reset values immediately. No DONE pulse.
- OUT_VALID never drops without OUT_READY, except on START or reset. OUT_DATA/OUT_IDX are stable while OUT_VALID && !OUT_READY.

## Timing
- START sampled at edge 0 gives LOAD after edge 0.
- Input word accepted at edge n appears on OUT_VALID/OUT_DATA after edge n (1-cycle latency).
- Throughput is one word per cycle with IN_VALID and OUT_READY held high. Under those conditions:
  - W[t] is valid after edge 1+t and consumed at edge 2+t.
  - DONE is high in the cycle after edge ROUNDS+1, i.e. after edge 65 (SHA-256) or 81 (SHA-512).
  - BUSY drops in that same cycle.
- The adder chain s0/s1 plus 4-input add is single-cycle combinational into the output register; no internal pipelining.

## Structure
- Shared package sha2_pkg holds:
  - rotation/shift constants per word width;
  - ROUNDS per width;
  - state encoding (IDLE, LOAD, EXPAND, DRAIN).
- Sub-module mod_sigma_small(WORD_W, SEL): one combinational s0/s1 function, instanced twice.

## Test plan
- SHA-256 "abc" block (M0=0x61626380, M1..M14=0, M15=0x00000018), OUT_READY=1 -> W16=0x61626380, W17=0x000F0000, OUT_IDX 0..63 in order, DONE after edge 65.
- WORD_W=64 "abc" block (M0=0x6162638000000000, M15=0x18) -> W16=0x6162638000000000, W17=0x00030000000000C0, 80 words, DONE after edge 81.
- Random OUT_READY backpressure (50%) plus random IN_VALID gaps -> OUT_DATA/OUT_IDX held stable while stalled; full sequence equals the golden model.
- IN_VALID held high during EXPAND with garbage IN_DATA -> IN_READY=0, output unaffected.
- START at T=30, then a new block -> OUT_VALID=0 next cycle, OUT_IDX restarts at 0, no DONE for the aborted block, new schedule is correct.
- RST_N low at T=20 -> all outputs at reset values immediately; BUSY=0; the next START runs a clean block.
